// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART command-frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sys_ctrl_pkg;

    // Command opcodes, matched against the first byte of a frame.
    localparam logic [7:0] CMD_WR     = 8'hAA;
    localparam logic [7:0] CMD_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;
    localparam logic [7:0] CMD_ALU    = 8'hDD;
    localparam logic [7:0] CMD_BWR    = 8'hEE;
    localparam logic [7:0] CMD_BRD    = 8'hFF;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_CNT,
        GET_DATA,
        GET_OPA,
        GET_OPB,
        GET_FUN,
        RF_RD_REQ,
        RF_RD_WAIT,
        ALU_RUN,
        ALU_WAIT,
        TX_PUSH
    } state_t;

    // Number of TX bytes needed to stream one ALU result.
    function automatic int out_bytes(input int alu_w, input int data_w);
        return alu_w / data_w;
    endfunction

endpackage

// File: rtl/tx_byte_serializer.sv
// Streams a loaded word to the TX FIFO one DATA_WIDTH byte at a time, LSB first.
// Latency: first byte offered the cycle after load; done pulses the cycle after the last byte.
// Backpressure: tx_vld is gated by fifo_full; the current byte is held until accepted.
//
// Ports: clk/rst (sync, active-high); load/word/nbytes start a new word;
//        fifo_full stalls output; tx_data/tx_vld feed the FIFO; done is a 1-cycle pulse.
module tx_byte_serializer #(
    parameter int WORD_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [CNT_WIDTH-1:0]  nbytes,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_vld,
    output logic                  done
);

    logic [WORD_WIDTH-1:0] shreg;
    logic [CNT_WIDTH-1:0]  remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                shreg     <= word;
                remaining <= nbytes;
            end else if (remaining != '0 && !fifo_full) begin
                shreg     <= shreg >> DATA_WIDTH;
                remaining <= remaining - 1'b1;
                done      <= (remaining == CNT_WIDTH'(1));
            end
        end
    end

    assign tx_data = shreg[DATA_WIDTH-1:0];
    // Gated directly by fifo_full so a strobe can never land on a full FIFO.
    assign tx_vld  = (remaining != '0) && !fifo_full;

endmodule

// File: rtl/sys_ctrl_burst.sv
// UART command-frame processor: decodes frames, drives RF/ALU handshakes, streams responses to TX FIFO.
// Latency: last RX byte of a read frame -> first TX_D_VLD is at least 3 cycles.
// Backpressure: FIFO_FULL stalls TX_PUSH with data held; RX bytes arriving in wait/push states are dropped.
//
// Ports: CLK/RST (sync, active-high); RX_P_DATA/RX_D_VLD command bytes in;
//        WR_EN/RD_EN/addr/WR_DATA/Rd_DATA/Rd_DATA_Valid register file; ALU_FUN/ALU_Enable/CLK_EN/ALU_OUT/ALU_OUT_Valid ALU;
//        TX_P_DATA/TX_D_VLD/FIFO_FULL TX FIFO; clk_div_en divider enable; cmd_error bad opcode or timeout pulse.
module sys_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    Rd_DATA,
    input  logic                     Rd_DATA_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_Valid,
    input  logic                     FIFO_FULL,
    output logic                     WR_EN,
    output logic                     RD_EN,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic [DATA_WIDTH-1:0]    WR_DATA,
    output logic [3:0]               ALU_FUN,
    output logic                     ALU_Enable,
    output logic                     CLK_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     clk_div_en,
    output logic                     cmd_error
);

    localparam int OUT_BYTES = out_bytes(ALU_OUT_WIDTH, DATA_WIDTH);
    localparam int BCNT_W    = $clog2(OUT_BYTES + 1);
    localparam int TMR_W     = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   state;
    logic [7:0]               cmd;
    logic [DATA_WIDTH-1:0]    cnt;
    logic [TMR_W-1:0]         timer;
    logic                     stall;
    logic                     timeout_hit;
    logic                     ser_load;
    logic                     ser_done;
    logic [ALU_OUT_WIDTH-1:0] ser_word;
    logic [BCNT_W-1:0]        ser_nbytes;

    // stall: a timed state that will neither advance nor see RX this cycle.
    always_comb begin
        stall = 1'b0;
        case (state)
            GET_ADDR, GET_CNT, GET_DATA,
            GET_OPA, GET_OPB, GET_FUN: stall = !RX_D_VLD;
            RF_RD_WAIT:                stall = !Rd_DATA_Valid;
            ALU_WAIT:                  stall = !ALU_OUT_Valid;
            default:                   stall = 1'b0;
        endcase
        timeout_hit = stall && !RX_D_VLD && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

        // Serializer captures read data / ALU result on the valid cycle itself.
        ser_load = (state == RF_RD_WAIT && Rd_DATA_Valid) ||
                   (state == ALU_WAIT && ALU_OUT_Valid);
        if (state == ALU_WAIT) begin
            ser_word   = ALU_OUT;
            ser_nbytes = BCNT_W'(OUT_BYTES);
        end else begin
            ser_word   = ALU_OUT_WIDTH'(Rd_DATA);
            ser_nbytes = BCNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cmd        <= '0;
            cnt        <= '0;
            timer      <= '0;
            WR_EN      <= 1'b0;
            RD_EN      <= 1'b0;
            addr       <= '0;
            WR_DATA    <= '0;
            ALU_FUN    <= '0;
            ALU_Enable <= 1'b0;
            CLK_EN     <= 1'b0;
            clk_div_en <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            clk_div_en <= 1'b1;
            WR_EN      <= 1'b0;
            RD_EN      <= 1'b0;
            ALU_Enable <= 1'b0;
            cmd_error  <= 1'b0;
            timer      <= (stall && !RX_D_VLD) ? timer + 1'b1 : '0;

            // Burst-write address advances once the write strobe has been seen.
            if (WR_EN && cmd == CMD_BWR)
                addr <= addr + 1'b1;

            case (state)
                IDLE: if (RX_D_VLD) begin
                    cmd <= RX_P_DATA[7:0];
                    case (RX_P_DATA)
                        DATA_WIDTH'(CMD_WR), DATA_WIDTH'(CMD_RD),
                        DATA_WIDTH'(CMD_BWR), DATA_WIDTH'(CMD_BRD): state <= GET_ADDR;
                        DATA_WIDTH'(CMD_ALU_OP):                    state <= GET_OPA;
                        DATA_WIDTH'(CMD_ALU):                       state <= GET_FUN;
                        default:                                    cmd_error <= 1'b1;
                    endcase
                end
                GET_ADDR: if (RX_D_VLD) begin
                    addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                    if (cmd == CMD_WR) begin
                        state <= GET_DATA;
                    end else if (cmd == CMD_RD) begin
                        state <= RF_RD_REQ;
                        RD_EN <= 1'b1;
                        cnt   <= DATA_WIDTH'(1);
                    end else begin
                        state <= GET_CNT;
                    end
                end
                GET_CNT: if (RX_D_VLD) begin
                    cnt <= RX_P_DATA;
                    if (RX_P_DATA == '0) begin
                        state <= IDLE;
                    end else if (cmd == CMD_BWR) begin
                        state <= GET_DATA;
                    end else begin
                        state <= RF_RD_REQ;
                        RD_EN <= 1'b1;
                    end
                end
                GET_DATA: if (RX_D_VLD) begin
                    WR_DATA <= RX_P_DATA;
                    WR_EN   <= 1'b1;
                    cnt     <= cnt - 1'b1;
                    if (cmd != CMD_BWR || cnt == DATA_WIDTH'(1))
                        state <= IDLE;
                end
                GET_OPA: if (RX_D_VLD) begin
                    addr    <= '0;
                    WR_DATA <= RX_P_DATA;
                    WR_EN   <= 1'b1;
                    state   <= GET_OPB;
                end
                GET_OPB: if (RX_D_VLD) begin
                    addr    <= ADDR_WIDTH'(1);
                    WR_DATA <= RX_P_DATA;
                    WR_EN   <= 1'b1;
                    state   <= GET_FUN;
                end
                GET_FUN: if (RX_D_VLD) begin
                    ALU_FUN    <= RX_P_DATA[3:0];
                    ALU_Enable <= 1'b1;
                    CLK_EN     <= 1'b1;
                    state      <= ALU_RUN;
                end
                ALU_RUN:   state <= ALU_WAIT;
                ALU_WAIT: if (ALU_OUT_Valid) begin
                    CLK_EN <= 1'b0;
                    state  <= TX_PUSH;
                end
                RF_RD_REQ: state <= RF_RD_WAIT;
                RF_RD_WAIT: if (Rd_DATA_Valid) begin
                    cnt   <= cnt - 1'b1;
                    state <= TX_PUSH;
                    if (cmd == CMD_BRD)
                        addr <= addr + 1'b1;
                end
                TX_PUSH: if (ser_done) begin
                    if (cmd == CMD_BRD && cnt != '0) begin
                        state <= RF_RD_REQ;
                        RD_EN <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Abort overrides whatever the state decoder chose.
            if (timeout_hit) begin
                state     <= IDLE;
                CLK_EN    <= 1'b0;
                cmd_error <= 1'b1;
            end
        end
    end

    tx_byte_serializer #(
        .WORD_WIDTH (ALU_OUT_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (BCNT_W)
    ) u_ser (
        .clk       (CLK),
        .rst       (RST),
        .load      (ser_load),
        .word      (ser_word),
        .nbytes    (ser_nbytes),
        .fifo_full (FIFO_FULL),
        .tx_data   (TX_P_DATA),
        .tx_vld    (TX_D_VLD),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Scoreboard bench for sys_ctrl_burst with RF and ALU responders.
// Latency: n/a.
// Backpressure: FIFO_FULL driven from the stimulus process.
module tb_sys_ctrl_burst;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int OW = 16;
    localparam int TO = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic [DW-1:0] Rd_DATA;
    logic          Rd_DATA_Valid;
    logic [OW-1:0] ALU_OUT;
    logic          ALU_OUT_Valid;
    logic          FIFO_FULL;
    logic          WR_EN, RD_EN, ALU_Enable, CLK_EN, TX_D_VLD, clk_div_en, cmd_error;
    logic [AW-1:0] addr;
    logic [DW-1:0] WR_DATA, TX_P_DATA;
    logic [3:0]    ALU_FUN;
    logic [30:0]   all_outs;

    always #5 CLK = ~CLK;

    sys_ctrl_burst #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .Rd_DATA(Rd_DATA), .Rd_DATA_Valid(Rd_DATA_Valid),
        .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid), .FIFO_FULL(FIFO_FULL),
        .WR_EN(WR_EN), .RD_EN(RD_EN), .addr(addr), .WR_DATA(WR_DATA),
        .ALU_FUN(ALU_FUN), .ALU_Enable(ALU_Enable), .CLK_EN(CLK_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .clk_div_en(clk_div_en),
        .cmd_error(cmd_error)
    );

    assign all_outs = {WR_EN, RD_EN, addr, WR_DATA, ALU_FUN, ALU_Enable, CLK_EN,
                       TX_P_DATA, TX_D_VLD, clk_div_en, cmd_error};

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          err_cyc  = 0;
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [3:0]  exp_fun[$];
    int          exp_err[$];
    logic [7:0]  frame[$];
    logic [7:0]  rf_mem[16];
    logic [3:0]  rd_a;
    logic [15:0] alu_result;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event 0x%0h, required none", name, act);
    endtask

    // Monitor: pops the expected response whenever the DUT presents one.
    initial begin
        forever begin
            @(negedge CLK);
            if (WR_EN) begin
                if (exp_wr.size() == 0) unexpected("wr_en", 32'({addr, WR_DATA}));
                else check("wr_en", 32'({addr, WR_DATA}), 32'(exp_wr.pop_front()));
            end
            if (RD_EN) begin
                if (exp_rd.size() == 0) unexpected("rd_en", 32'(addr));
                else check("rd_addr", 32'(addr), 32'(exp_rd.pop_front()));
            end
            if (TX_D_VLD) begin
                check("tx_while_full", 32'(FIFO_FULL), 32'(0));
                if (exp_tx.size() == 0) unexpected("tx_d_vld", 32'(TX_P_DATA));
                else check("tx_data", 32'(TX_P_DATA), 32'(exp_tx.pop_front()));
            end
            if (ALU_Enable) begin
                check("clk_en_at_start", 32'(CLK_EN), 32'(1));
                if (exp_fun.size() == 0) unexpected("alu_enable", 32'(ALU_FUN));
                else check("alu_fun", 32'(ALU_FUN), 32'(exp_fun.pop_front()));
            end
            if (cmd_error) begin
                err_cyc = cyc;
                if (exp_err.size() == 0) unexpected("cmd_error", 32'(1));
                else void'(exp_err.pop_front());
            end
        end
    end

    // Register file responder: data valid one cycle after RD_EN.
    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h80 + 8'(i);
        Rd_DATA = '0;
        Rd_DATA_Valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (WR_EN) rf_mem[addr] = WR_DATA;
            if (RD_EN) begin
                rd_a = addr;
                @(posedge CLK); #1;
                Rd_DATA = rf_mem[rd_a];
                Rd_DATA_Valid = 1'b1;
                @(posedge CLK); #1;
                Rd_DATA_Valid = 1'b0;
            end
        end
    end

    // ALU responder: result valid one cycle after ALU_Enable.
    initial begin
        ALU_OUT = '0;
        ALU_OUT_Valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (ALU_Enable) begin
                @(posedge CLK); #1;
                ALU_OUT = alu_result;
                ALU_OUT_Valid = 1'b1;
                @(posedge CLK); #1;
                ALU_OUT_Valid = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat (2) @(posedge CLK);
        #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_tx.size() + exp_fun.size() + exp_err.size()) != 0
               && k < budget) begin
            @(posedge CLK);
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL drain: %0d events pending after %0d cycles, required 0",
                     exp_wr.size() + exp_rd.size() + exp_tx.size() + exp_fun.size() + exp_err.size(), k);
        end
        repeat (6) @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int lat;
        RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; FIFO_FULL = 1'b0; alu_result = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", 32'(all_outs), 32'(0));
        RST = 1'b0;
        @(posedge CLK); #1;
        check("clk_div_en_after_reset", 32'(clk_div_en), 32'(1));

        // Single write then read back.
        exp_wr.push_back({4'h5, 8'h3C});
        frame = '{8'hAA, 8'h05, 8'h3C}; send_frame(); drain(100);
        exp_rd.push_back(4'h5); exp_tx.push_back(8'h3C);
        frame = '{8'hBB, 8'h05}; send_frame(); drain(100);

        // ALU with operands, result 0x000D streamed LSB first.
        alu_result = 16'h000D;
        exp_wr.push_back({4'h0, 8'h0A}); exp_wr.push_back({4'h1, 8'h03});
        exp_fun.push_back(4'h0); exp_tx.push_back(8'h0D); exp_tx.push_back(8'h00);
        frame = '{8'hCC, 8'h0A, 8'h03, 8'h00}; send_frame(); drain(100);
        check("clk_en_after_alu", 32'(CLK_EN), 32'(0));

        // ALU without operands.
        alu_result = 16'hBEEF;
        exp_fun.push_back(4'h3); exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
        frame = '{8'hDD, 8'h03}; send_frame(); drain(100);

        // Burst write wrapping past the top address.
        exp_wr.push_back({4'hE, 8'h11}); exp_wr.push_back({4'hF, 8'h22}); exp_wr.push_back({4'h0, 8'h33});
        frame = '{8'hEE, 8'h0E, 8'h03, 8'h11, 8'h22, 8'h33}; send_frame(); drain(100);

        // Zero-length bursts: no traffic at all.
        frame = '{8'hEE, 8'h04, 8'h00}; send_frame(); drain(20);
        frame = '{8'hFF, 8'h05, 8'h00}; send_frame(); drain(20);

        // Burst read wrapping: F then 0.
        exp_rd.push_back(4'hF); exp_rd.push_back(4'h0);
        exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
        frame = '{8'hFF, 8'h0F, 8'h02}; send_frame(); drain(100);

        // Burst read under backpressure.
        FIFO_FULL = 1'b1;
        exp_rd.push_back(4'h2); exp_rd.push_back(4'h3);
        exp_tx.push_back(8'h82); exp_tx.push_back(8'h83);
        frame = '{8'hFF, 8'h02, 8'h02}; send_frame();
        repeat (13) @(posedge CLK);
        #1;
        check("tx_held_while_full", 32'(exp_tx.size()), 32'(2));
        check("rd_held_while_full", 32'(exp_rd.size()), 32'(1));
        FIFO_FULL = 1'b0;
        drain(100);

        // Mid-frame timeout: no write, one error pulse.
        exp_err.push_back(1);
        frame = '{8'hAA, 8'h05}; send_frame();
        t0 = cyc;
        drain(TO + 50);
        lat = err_cyc - t0;
        check("timeout_latency_in_range", 32'(lat >= TO && lat <= TO + 1), 32'(1));

        // Unknown opcode.
        exp_err.push_back(1);
        frame = '{8'h12}; send_frame(); drain(20);

        // Reset in the middle of a burst write, after the second data byte.
        exp_wr.push_back({4'h0, 8'h11}); exp_wr.push_back({4'h1, 8'h22});
        frame = '{8'hEE, 8'h00, 8'h04, 8'h11, 8'h22}; send_frame();
        RST = 1'b1;
        @(posedge CLK); #1;
        check("outputs_after_mid_reset", 32'(all_outs), 32'(0));
        RST = 1'b0;
        drain(20);

        // Normal operation resumes.
        exp_wr.push_back({4'h7, 8'h5A});
        frame = '{8'hAA, 8'h07, 8'h5A}; send_frame(); drain(100);
        exp_rd.push_back(4'h7); exp_tx.push_back(8'h5A);
        frame = '{8'hBB, 8'h07}; send_frame(); drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
